// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
// Optional EMERGENCY_STOP_EN build adds an estop input to the bus interface.
package elevator_pkg;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Counter width able to hold 0 .. cycles-1, never narrower than one bit
  function automatic int timerWidth(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/elevator_scan_controller_if.sv
// Call/indicator bus between the elevator controller and its environment.
// With EMERGENCY_STOP_EN defined the bus also carries the estop input.
interface elevator_scan_controller_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
);
  logic [NUM_FLOORS-1:0] request;
  logic [FLOOR_W-1:0]    floor;
  logic                  moving;
  logic                  dir_up;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
`ifdef EMERGENCY_STOP_EN
  logic                  estop;

  modport master (output request, output estop,
                  input floor, input moving, input dir_up, input door_open, input pending);
  modport slave  (input request, input estop,
                  output floor, output moving, output dir_up, output door_open, output pending);
`else
  modport master (output request,
                  input floor, input moving, input dir_up, input door_open, input pending);
  modport slave  (input request,
                  output floor, output moving, output dir_up, output door_open, output pending);
`endif
endinterface

// File: rtl/elevator_call_lookahead.sv
// Combinational summary of outstanding calls relative to a given floor.
module elevator_call_lookahead #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input  logic [NUM_FLOORS-1:0] i_calls,
  input  logic [FLOOR_W-1:0]    i_floor,
  output logic                  o_callsAbove,
  output logic                  o_callsBelow,
  output logic                  o_callHere
);

  always_comb begin
    o_callsAbove = 1'b0;
    o_callsBelow = 1'b0;
    o_callHere   = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(i_floor))  o_callsAbove = o_callsAbove | i_calls[i];
      if (i < int'(i_floor))  o_callsBelow = o_callsBelow | i_calls[i];
      if (i == int'(i_floor)) o_callHere   = i_calls[i];
    end
  end

endmodule

// File: rtl/elevator_scan_controller.sv
// N-floor SCAN elevator controller: latches calls, travels, dwells at stops.
// EMERGENCY_STOP_EN enables the estop behaviour (finish segment, hold door open).
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input logic                clk,
  input logic                reset_n,
  elevator_scan_controller_if.slave bus
);

  localparam int TRAVEL_W = timerWidth(TRAVEL_CYCLES);
  localparam int DOOR_W   = timerWidth(DOOR_CYCLES);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]  ONE_FLOOR   = FLOOR_W'(1);

  state_t                r_state, w_stateNxt;
  logic [FLOOR_W-1:0]    r_floor, w_floorNxt, w_arrivalFloor;
  logic                  r_dirUp, w_dirUpNxt, w_dirFlip;
  logic [NUM_FLOORS-1:0] r_pending, w_pendingNxt, w_calls, w_served, w_reqMask;
  logic [TRAVEL_W-1:0]   r_travelCnt, w_travelCntNxt;
  logic [DOOR_W-1:0]     r_doorCnt, w_doorCntNxt;
  logic                  r_estopSeen, w_estopSeenNxt;
  logic                  w_estop, w_doorRestart;
  logic                  w_hereAbove, w_hereBelow, w_hereCall, w_hereAhead, w_hereBehind;
  logic                  w_arrAbove, w_arrBelow, w_arrCall, w_arrAhead;

`ifdef EMERGENCY_STOP_EN
  assign w_estop = bus.estop;
`else
  assign w_estop = 1'b0;
`endif

  // A call for the floor whose door is open extends the dwell instead of being latched
  assign w_reqMask      = (r_state == DOOR) ? ~(NUM_FLOORS'(1) << r_floor) : '1;
  assign w_doorRestart  = (r_state == DOOR) && bus.request[r_floor] && !w_estop;
  assign w_calls        = w_estop ? '0 : (r_pending | (bus.request & w_reqMask));
  assign w_arrivalFloor = r_dirUp ? r_floor + ONE_FLOOR : r_floor - ONE_FLOOR;
  assign w_dirFlip      = (r_dirUp == DIR_UP) ? DIR_DN : DIR_UP;

  elevator_call_lookahead #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) uHere (
    .i_calls(w_calls), .i_floor(r_floor),
    .o_callsAbove(w_hereAbove), .o_callsBelow(w_hereBelow), .o_callHere(w_hereCall)
  );

  elevator_call_lookahead #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) uArrive (
    .i_calls(w_calls), .i_floor(w_arrivalFloor),
    .o_callsAbove(w_arrAbove), .o_callsBelow(w_arrBelow), .o_callHere(w_arrCall)
  );

  assign w_hereAhead  = r_dirUp ? w_hereAbove : w_hereBelow;
  assign w_hereBehind = r_dirUp ? w_hereBelow : w_hereAbove;
  assign w_arrAhead   = r_dirUp ? w_arrAbove  : w_arrBelow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_stateNxt;
  end

  always_comb begin
    w_stateNxt     = r_state;
    w_floorNxt     = r_floor;
    w_dirUpNxt     = r_dirUp;
    w_travelCntNxt = r_travelCnt;
    w_doorCntNxt   = r_doorCnt;
    w_estopSeenNxt = r_estopSeen | w_estop;
    w_served       = '0;
    unique case (r_state)
      IDLE: begin
        if (w_estop) begin
          w_stateNxt   = DOOR;
          w_doorCntNxt = '0;
        end else if (w_hereCall) begin
          w_stateNxt   = DOOR;
          w_doorCntNxt = '0;
          w_served     = NUM_FLOORS'(1) << r_floor;
        end else if (w_hereAhead) begin
          w_stateNxt     = MOVE;
          w_travelCntNxt = '0;
        end else if (w_hereBehind) begin
          w_stateNxt     = MOVE;
          w_travelCntNxt = '0;
          w_dirUpNxt     = w_dirFlip;
        end
      end
      MOVE: begin
        if (r_travelCnt == TRAVEL_LAST) begin
          w_travelCntNxt = '0;
          w_floorNxt     = w_arrivalFloor;
          if (w_estop || w_arrCall) begin
            w_stateNxt   = DOOR;
            w_doorCntNxt = '0;
            w_served     = w_estop ? '0 : (NUM_FLOORS'(1) << w_arrivalFloor);
          end else if (!w_arrAhead) begin
            w_stateNxt = IDLE;
          end
        end else begin
          w_travelCntNxt = r_travelCnt + TRAVEL_W'(1);
        end
      end
      DOOR: begin
        if (w_estop || w_doorRestart) begin
          w_doorCntNxt = '0;
        end else if (r_doorCnt == DOOR_LAST) begin
          // After an emergency stop the car parks in IDLE before resuming service
          w_doorCntNxt   = '0;
          w_estopSeenNxt = 1'b0;
          w_stateNxt     = IDLE;
          if (!r_estopSeen && w_hereAhead) begin
            w_stateNxt     = MOVE;
            w_travelCntNxt = '0;
          end else if (!r_estopSeen && w_hereBehind) begin
            w_stateNxt     = MOVE;
            w_travelCntNxt = '0;
            w_dirUpNxt     = w_dirFlip;
          end
        end else begin
          w_doorCntNxt = r_doorCnt + DOOR_W'(1);
        end
      end
      default: w_stateNxt = IDLE;
    endcase
    w_pendingNxt = w_calls & ~w_served;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_floor     <= '0;
      r_dirUp     <= DIR_UP;
      r_pending   <= '0;
      r_travelCnt <= '0;
      r_doorCnt   <= '0;
      r_estopSeen <= 1'b0;
    end else begin
      r_floor     <= w_floorNxt;
      r_dirUp     <= w_dirUpNxt;
      r_pending   <= w_pendingNxt;
      r_travelCnt <= w_travelCntNxt;
      r_doorCnt   <= w_doorCntNxt;
      r_estopSeen <= w_estopSeenNxt;
    end
  end

  always_comb begin
    bus.floor     = r_floor;
    bus.moving    = (r_state == MOVE);
    bus.dir_up    = r_dirUp;
    bus.door_open = (r_state == DOOR);
    bus.pending   = r_pending;
  end

endmodule
